// File: rtl/pin_entry_ctrl.sv
// pin_entry_ctrl: collects decimal keypad digits into a BCD PIN and strobes it
// into a downstream latch on ENTER, with clear/cancel keys and an inactivity timeout.
module pin_entry_ctrl #(
    parameter int DIGITS  = 4,
    parameter int TIMEOUT = 1000
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_key_valid,
    input  logic [3:0]          i_key_code,
    output logic [4*DIGITS-1:0] o_pin_data,
    output logic                o_latch_en,
    output logic [3:0]          o_digit_count,
    output logic                o_busy,
    output logic                o_entry_err,
    output logic                o_timeout
);
    typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_LOAD} state_t;
    state_t              r_state;
    logic [4*DIGITS-1:0] r_buf, r_pin;
    logic [3:0]          r_cnt;
    logic [15:0]         r_timer;
    logic                r_latch, r_err, r_to, r_busy;
    logic                w_digit, w_key, w_full;

    assign w_digit = i_key_valid && (i_key_code <= 4'd9);
    // codes 0xD-0xF are invisible: they neither act nor restart the timer
    assign w_key   = i_key_valid && (i_key_code <= 4'hC);
    assign w_full  = r_cnt == 4'(DIGITS);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
            r_buf   <= '0;
            r_pin   <= '0;
            r_cnt   <= '0;
            r_timer <= '0;
            r_latch <= 1'b0;
            r_err   <= 1'b0;
            r_to    <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_latch <= 1'b0;
            r_err   <= 1'b0;
            r_to    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_digit) begin
                        r_buf   <= (4*DIGITS)'(i_key_code);
                        r_cnt   <= 4'd1;
                        r_timer <= '0;
                        r_state <= S_ENTRY;
                        r_busy  <= 1'b1;
                    end
                end
                S_ENTRY: begin
                    if (w_key) begin
                        r_timer <= '0;
                        if (w_digit) begin
                            if (w_full) r_err <= 1'b1;
                            else begin
                                r_buf <= (r_buf << 4) | (4*DIGITS)'(i_key_code);
                                r_cnt <= r_cnt + 4'd1;
                            end
                        end else if (i_key_code == 4'hA) begin
                            r_buf <= '0;
                            r_cnt <= '0;
                        end else if (i_key_code == 4'hB) begin
                            if (w_full) begin
                                r_pin   <= r_buf;
                                r_latch <= 1'b1;
                                r_state <= S_LOAD;
                            end else r_err <= 1'b1;
                        end else begin
                            r_buf   <= '0;
                            r_cnt   <= '0;
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else if (r_timer == 16'(TIMEOUT - 1)) begin
                        r_to    <= 1'b1;
                        r_buf   <= '0;
                        r_cnt   <= '0;
                        r_timer <= '0;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else r_timer <= r_timer + 16'd1;
                end
                default: begin
                    r_buf   <= '0;
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_pin_data    = r_pin;
    assign o_latch_en    = r_latch;
    assign o_digit_count = r_cnt;
    assign o_busy        = r_busy;
    assign o_entry_err   = r_err;
    assign o_timeout     = r_to;
endmodule

// File: tb/tb_pin_entry_ctrl.sv
// tb_pin_entry_ctrl: directed and randomized key streams checked against a
// queue-based model of the PIN entry rules.
module tb_pin_entry_ctrl;
    localparam int DP = 4;
    localparam int TP = 20;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            key_valid = 1'b0;
    logic [3:0]      key_code = 4'd0;
    logic [4*DP-1:0] pin_data;
    logic            latch_en, busy, entry_err, timeout;
    logic [3:0]      digit_count;

    int n_cmp = 0;
    int n_bad = 0;

    int              m_mode = 0;
    int              q[$];
    int              m_idle = 0;
    logic [4*DP-1:0] m_pin = '0;
    logic            m_latch = 1'b0, m_err = 1'b0, m_to = 1'b0;

    pin_entry_ctrl #(.DIGITS(DP), .TIMEOUT(TP)) dut (
        .i_clk(clk),
        .i_rst(rst_n),
        .i_key_valid(key_valid),
        .i_key_code(key_code),
        .o_pin_data(pin_data),
        .o_latch_en(latch_en),
        .o_digit_count(digit_count),
        .o_busy(busy),
        .o_entry_err(entry_err),
        .o_timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4*DP-1:0] pin_of();
        logic [4*DP-1:0] p = '0;
        foreach (q[i]) p = (p << 4) | (4*DP)'(q[i]);
        return p;
    endfunction

    // mode: 0 idle, 1 collecting digits, 2 loading
    task automatic model(input logic v, input logic [3:0] c, input logic rn);
        m_latch = 1'b0;
        m_err   = 1'b0;
        m_to    = 1'b0;
        if (!rn) begin
            m_mode = 0;
            q.delete();
            m_pin  = '0;
            m_idle = 0;
        end else if (m_mode == 2) begin
            m_mode = 0;
            q.delete();
        end else if (m_mode == 0) begin
            if (v && c < 10) begin
                q.delete();
                q.push_back(int'(c));
                m_mode = 1;
                m_idle = 0;
            end
        end else if (v && c < 13) begin
            m_idle = 0;
            if (c < 10) begin
                if (q.size() < DP) q.push_back(int'(c));
                else m_err = 1'b1;
            end else if (c == 10) q.delete();
            else if (c == 11) begin
                if (q.size() == DP) begin
                    m_mode  = 2;
                    m_latch = 1'b1;
                    m_pin   = pin_of();
                end else m_err = 1'b1;
            end else begin
                q.delete();
                m_mode = 0;
            end
        end else begin
            m_idle++;
            if (m_idle == TP) begin
                m_to = 1'b1;
                q.delete();
                m_mode = 0;
                m_idle = 0;
            end
        end
    endtask

    task automatic step(input logic v, input logic [3:0] c, input logic rn);
        key_valid = v;
        key_code  = c;
        rst_n     = rn;
        model(v, c, rn);
        @(posedge clk);
        #1;
        chk("pin_data", 32'(pin_data), 32'(m_pin));
        chk("latch_en", 32'(latch_en), 32'(m_latch));
        chk("digit_count", 32'(digit_count), 32'(q.size()));
        chk("busy", 32'(busy), 32'(m_mode != 0));
        chk("entry_err", 32'(entry_err), 32'(m_err));
        chk("timeout", 32'(timeout), 32'(m_to));
    endtask

    task automatic key(input logic [3:0] c);
        step(1'b1, c, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b1);
    endtask

    initial begin
        step(1'b0, 4'd0, 1'b0);
        chk("rst_pin", 32'(pin_data), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'hB);
        chk("p1234_latch", 32'(latch_en), 32'h1);
        chk("p1234_pin", 32'(pin_data), 32'h1234);
        idle(1);
        chk("p1234_after_latch", 32'(latch_en), 32'h0);
        chk("p1234_after_cnt", 32'(digit_count), 32'h0);
        chk("p1234_after_busy", 32'(busy), 32'h0);
        key(4'd5); key(4'd6); key(4'hB);
        chk("short_enter_err", 32'(entry_err), 32'h1);
        chk("short_enter_nolatch", 32'(latch_en), 32'h0);
        key(4'd7); key(4'd8); key(4'hB);
        chk("p5678_pin", 32'(pin_data), 32'h5678);
        chk("p5678_latch", 32'(latch_en), 32'h1);
        idle(1);
        key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd9);
        chk("fifth_digit_err", 32'(entry_err), 32'h1);
        chk("fifth_digit_cnt", 32'(digit_count), 32'h4);
        key(4'hA); key(4'd9); key(4'd8); key(4'd7); key(4'd6); key(4'hB);
        chk("p9876_pin", 32'(pin_data), 32'h9876);
        idle(1);
        key(4'd1); key(4'd2); idle(TP);
        chk("timeout_pulse", 32'(timeout), 32'h1);
        chk("timeout_pin_kept", 32'(pin_data), 32'h9876);
        chk("timeout_cnt", 32'(digit_count), 32'h0);
        idle(1);
        chk("timeout_single", 32'(timeout), 32'h0);
        key(4'd1); key(4'd2); idle(TP - 1); key(4'd3);
        chk("expiry_key_no_timeout", 32'(timeout), 32'h0);
        chk("expiry_key_cnt", 32'(digit_count), 32'h3);
        key(4'hC);
        key(4'd4); key(4'd3); key(4'd2); step(1'b0, 4'd0, 1'b0);
        chk("midreset_cnt", 32'(digit_count), 32'h0);
        chk("midreset_pin", 32'(pin_data), 32'h0);
        key(4'd1); key(4'd1); key(4'd1); key(4'd1); key(4'hB);
        chk("p1111_pin", 32'(pin_data), 32'h1111);
        idle(1);
        key(4'hA); key(4'hB); key(4'hC); key(4'd5); key(4'hC);
        chk("cancel_no_err", 32'(entry_err), 32'h0);
        chk("cancel_pin_kept", 32'(pin_data), 32'h1111);
        key(4'd2); key(4'd2); key(4'd2); key(4'd2); step(1'b1, 4'hB, 1'b0);
        chk("reset_on_enter_latch", 32'(latch_en), 32'h0);
        key(4'd3); key(4'd3); key(4'd3); key(4'd3); key(4'hB); step(1'b0, 4'd0, 1'b0);
        chk("reset_in_load_pin", 32'(pin_data), 32'h0);
        for (int i = 0; i < 4000; i++) begin
            int ph, pct;
            logic v;
            logic [3:0] c;
            ph  = (i / 200) % 4;
            pct = (ph == 0) ? 50 : (ph == 1) ? 10 : (ph == 2) ? 90 : 3;
            v   = $urandom_range(0, 99) < pct;
            c   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            step(v, c, $urandom_range(0, 299) != 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pin_entry_ctrl.md
PIN_ENTRY_CTRL -- requirements
Module: pin_entry_ctrl

Interface
REQ-001 Parameter DIGITS, default 4, number of decimal PIN digits collected (range 1..8).
REQ-002 Parameter TIMEOUT, default 1000, idle clock cycles allowed between keys in ENTRY (range 2..65535).
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-005 key_valid  input  1  one-cycle strobe: key_code is valid this cycle.
REQ-006 key_code  input  4  0x0-0x9 digit; 0xA CLEAR; 0xB ENTER; 0xC CANCEL; 0xD-0xF ignored.
REQ-007 pin_data  output  4*DIGITS  BCD PIN feeding the downstream latch dataIn; first-entered digit in the most-significant nibble.
REQ-008 latch_en  output  1  drives the downstream latch en; high exactly one cycle per accepted PIN.
REQ-009 digit_count  output  4  number of digits currently buffered (0..DIGITS).
REQ-010 busy  output  1  high while in ENTRY or LOAD.
REQ-011 entry_err  output  1  one-cycle pulse on a rejected key.
REQ-012 timeout  output  1  one-cycle pulse when the ENTRY inactivity timer expires.

Function
REQ-013 The block SHALL implement states IDLE, ENTRY, LOAD, each key_valid cycle processing at most one key.
REQ-014 IDLE: digit key SHALL clear buffer, store digit, set digit_count=1, go ENTRY; non-digit keys SHALL be ignored without entry_err.
REQ-015 ENTRY, digit with digit_count<DIGITS: buffer shifts left one nibble, digit enters LSB nibble, digit_count+1.
REQ-016 ENTRY, digit with digit_count==DIGITS: buffer unchanged, entry_err pulses next cycle.
REQ-017 ENTRY, CLEAR: buffer=0, digit_count=0, remain ENTRY.
REQ-018 ENTRY, ENTER with digit_count==DIGITS: go LOAD; with digit_count<DIGITS: entry_err pulses, state and buffer unchanged.
REQ-019 ENTRY, CANCEL: buffer=0, digit_count=0, go IDLE; no entry_err.
REQ-020 ENTRY, key codes 0xD-0xF: ignored, no entry_err, timer not restarted.
REQ-021 LOAD (exactly one cycle): pin_data<=buffer registered on entry to LOAD so pin_data is stable in the same cycle latch_en=1; next state IDLE; buffer and digit_count cleared on leaving LOAD; keys in LOAD ignored.
REQ-022 pin_data SHALL change only on entry to LOAD and on reset; it holds its value through all other states.
REQ-023 Inactivity timer: counts cycles in ENTRY, restarts to 0 on every accepted or rejected key (0x0-0xC); at count TIMEOUT-1 without a key, next cycle timeout pulses, buffer/digit_count clear, state IDLE.
REQ-024 Key arriving in the same cycle the timer expires SHALL take priority; no timeout in that case.
REQ-025 All outputs registered; latch_en, entry_err, timeout SHALL never be high in consecutive cycles from one event.
REQ-026 Digit entry is not blocked by busy; no back-pressure; keys presented while in LOAD are lost.

Reset
REQ-027 rst=0 at a clock edge SHALL force IDLE, buffer=0, pin_data=0, digit_count=0, latch_en=0, busy=0, entry_err=0, timeout=0, timer=0, overriding any key that cycle, including mid-entry and during LOAD (latch_en suppressed).

Verification
REQ-028 Reset, then digits 1,2,3,4, ENTER -> one-cycle latch_en with pin_data=0x1234, then IDLE, digit_count=0, busy=0.
REQ-029 Digits 5,6, ENTER -> entry_err pulse, no latch_en; then 7,8, ENTER -> pin_data=0x5678, latch_en pulse.
REQ-030 Digits 1,2,3,4,9 -> entry_err on fifth digit, digit_count stays 4; CLEAR, 9,8,7,6, ENTER -> pin_data=0x9876.
REQ-031 Digits 1,2 then no keys for TIMEOUT cycles -> timeout pulse, IDLE, digit_count=0, pin_data unchanged from previous PIN; key on exact expiry cycle -> no timeout.
REQ-032 Digits 4,3,2 then rst=0 one cycle -> all outputs zero; following 1,1,1,1, ENTER -> pin_data=0x1111.
REQ-033 ENTER/CLEAR/CANCEL in IDLE and CANCEL mid-entry -> no latch_en, no entry_err, pin_data unchanged.
